magnetron_power_ctrl: RTL and testbench

MAGNETRON_POWER_CTRL -- requirements
Module: magnetron_power_ctrl

---
 rtl/magnetron_power_ctrl_if.sv | 26 ++
 rtl/magnetron_power_ctrl.sv | 90 +++++++++
 tb/tb_magnetron_power_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/magnetron_power_ctrl_if.sv
// Control/status bundle between the oven front panel and the magnetron power controller.
// The master drives the requests; the slave (controller) returns drive and state.
interface magnetron_power_ctrl_if #(
  parameter int unsigned LEVEL_W = 4
);
  logic               startn;
  logic               stopn;
  logic               clearn;
  logic               door_closed;
  logic               timer_done;
  logic               tick;
  logic [LEVEL_W-1:0] power_level;
  logic               mag_on;
  logic [1:0]         state;
  logic               done;

  modport master (
    output startn, stopn, clearn, door_closed, timer_done, tick, power_level,
    input  mag_on, state, done
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done, tick, power_level,
    output mag_on, state, done
  );
endinterface

// File: rtl/magnetron_power_ctrl.sv
// Microwave magnetron controller: IDLE/COOK/PAUSE/DONE sequencing plus a tick-driven
// duty cycle whose on-time is the power level latched on each entry into COOK.
module magnetron_power_ctrl #(
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned MAX_LEVEL = 10
) (
  input logic                    clk,
  input logic                    rst,
  magnetron_power_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCook  = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam logic [LEVEL_W-1:0] MaxLvl  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] One     = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LastCnt = MaxLvl - One;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic [LEVEL_W-1:0] cnt_q, cnt_d;
  logic               mag_on_q;
  logic               done_q;
  logic               start_ok;

  assign start_ok = !bus.startn && bus.stopn && bus.clearn && bus.door_closed &&
                    !bus.timer_done;

  // Each branch follows the request priority clear > stop > door > timer > start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StCook;
      end
      StCook: begin
        if (!bus.clearn)                         state_d = StIdle;
        else if (!bus.stopn || !bus.door_closed) state_d = StPause;
        else if (bus.timer_done)                 state_d = StDone;
      end
      StPause: begin
        // An open door only blocks resuming; it never masks clear or timer expiry.
        if (!bus.clearn)          state_d = StIdle;
        else if (!bus.stopn)      state_d = StPause;
        else if (bus.timer_done)  state_d = StDone;
        else if (start_ok)        state_d = StCook;
      end
      StDone: begin
        if (!bus.clearn || !bus.door_closed) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (state_d == StCook && state_q != StCook) begin
      lvl_d = (bus.power_level > MaxLvl) ? MaxLvl : bus.power_level;
      cnt_d = '0;
    end else if (state_q == StCook && state_d == StCook && bus.tick) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + One;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lvl_q    <= '0;
      cnt_q    <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      mag_on_q <= (state_d == StCook) && (cnt_d < lvl_d);
      done_q   <= (state_d == StDone);
    end
  end

  // Door interlock acts combinationally so drive drops in the cycle the door opens.
  assign bus.mag_on = mag_on_q & bus.door_closed;
  assign bus.state  = state_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Bench for magnetron_power_ctrl: vector table, directed duty/door sequences and
// randomized traffic checked against an abstract tick-count model.
module tb_magnetron_power_ctrl;

  localparam int unsigned LW   = 4;
  localparam int unsigned MAXL = 10;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  magnetron_power_ctrl_if #(.LEVEL_W(LW)) bus ();

  magnetron_power_ctrl #(
    .LEVEL_W   (LW),
    .MAX_LEVEL (MAXL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode (0 idle, 1 cook, 2 pause, 3 done), latched level, ticks since COOK entry.
  int m_state = 0;
  int m_lvl   = 0;
  int m_ticks = 0;

  typedef struct {
    bit         r, startn, stopn, clearn, door, timer, tick;
    logic [3:0] pl;
    logic [1:0] st;
    bit         mag, done;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mkv(bit r, bit sn, bit sp, bit cl, bit dr, bit tm, bit tk,
                               logic [3:0] pl, logic [1:0] st, bit mg, bit dn);
    vec_t v;
    v.r = r; v.startn = sn; v.stopn = sp; v.clearn = cl; v.door = dr;
    v.timer = tm; v.tick = tk; v.pl = pl; v.st = st; v.mag = mg; v.done = dn;
    return v;
  endfunction

  function automatic int model_next(int s, bit sn, bit sp, bit cl, bit dr, bit tm);
    bit start_ok;
    start_ok = !sn && sp && cl && dr && !tm;
    case (s)
      0: return start_ok ? 1 : 0;
      1: begin
        if (!cl) return 0;
        if (!sp || !dr) return 2;
        if (tm) return 3;
        return 1;
      end
      2: begin
        if (!cl) return 0;
        if (!sp) return 2;
        if (tm) return 3;
        if (start_ok) return 1;
        return 2;
      end
      default: return (!cl || !dr) ? 0 : 3;
    endcase
  endfunction

  task automatic model_edge();
    int nxt;
    if (rst) begin
      m_state = 0;
      m_lvl   = 0;
      m_ticks = 0;
    end else begin
      nxt = model_next(m_state, bus.startn, bus.stopn, bus.clearn, bus.door_closed,
                       bus.timer_done);
      if (nxt == 1 && m_state != 1) begin
        m_lvl   = (int'(bus.power_level) > int'(MAXL)) ? int'(MAXL) : int'(bus.power_level);
        m_ticks = 0;
      end else if (nxt == 1 && bus.tick) begin
        m_ticks++;
      end
      m_state = nxt;
    end
  endtask

  function automatic bit model_mag();
    return (m_state == 1) && ((m_ticks % int'(MAXL)) < m_lvl) && bus.door_closed;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"}, {6'b0, bus.state}, 8'(m_state));
    check({tag, "_mag"},   {7'b0, bus.mag_on}, {7'b0, model_mag()});
    check({tag, "_done"},  {7'b0, bus.done}, {7'b0, (m_state == 3)});
  endtask

  task automatic set_in(bit r, bit sn, bit sp, bit cl, bit dr, bit tm, bit tk, logic [3:0] pl);
    rst             = r;
    bus.startn      = sn;
    bus.stopn       = sp;
    bus.clearn      = cl;
    bus.door_closed = dr;
    bus.timer_done  = tm;
    bus.tick        = tk;
    bus.power_level = pl;
  endtask

  initial begin
    set_in(H, H, H, H, H, L, L, 4'd4);

    //              rst startn stopn clearn door timer tick pl      st    mag done
    tbl[0]  = mkv(H, H, H, H, H, L, L, 4'd4,  2'd0, L, L);
    tbl[1]  = mkv(L, L, H, H, H, L, L, 4'd4,  2'd1, H, L);
    tbl[2]  = mkv(L, H, H, H, H, L, H, 4'd4,  2'd1, H, L);
    tbl[3]  = mkv(L, H, H, H, H, L, H, 4'd4,  2'd1, H, L);
    tbl[4]  = mkv(L, H, H, H, H, L, H, 4'd4,  2'd1, H, L);
    tbl[5]  = mkv(L, H, H, H, H, L, H, 4'd4,  2'd1, L, L);
    tbl[6]  = mkv(L, H, H, H, H, L, L, 4'd15, 2'd1, L, L);
    tbl[7]  = mkv(L, H, L, H, H, H, L, 4'd15, 2'd2, L, L);
    tbl[8]  = mkv(L, H, H, H, H, H, L, 4'd15, 2'd3, L, H);
    tbl[9]  = mkv(L, L, H, H, H, L, L, 4'd15, 2'd3, L, H);
    tbl[10] = mkv(L, H, H, L, H, L, L, 4'd15, 2'd0, L, L);
    tbl[11] = mkv(L, L, H, H, H, L, L, 4'd15, 2'd1, H, L);
    tbl[12] = mkv(L, H, H, H, H, L, H, 4'd15, 2'd1, H, L);
    tbl[13] = mkv(L, H, H, L, H, L, L, 4'd0,  2'd0, L, L);
    tbl[14] = mkv(L, L, H, H, H, L, L, 4'd0,  2'd1, L, L);
    tbl[15] = mkv(L, H, H, H, H, L, H, 4'd0,  2'd1, L, L);
    tbl[16] = mkv(L, L, H, H, L, L, L, 4'd3,  2'd2, L, L);
    tbl[17] = mkv(L, L, H, H, H, L, L, 4'd3,  2'd1, H, L);
    tbl[18] = mkv(H, H, H, H, H, L, L, 4'd3,  2'd0, L, L);
    tbl[19] = mkv(L, L, H, H, L, L, L, 4'd3,  2'd0, L, L);
    tbl[20] = mkv(H, L, H, H, H, L, L, 4'd3,  2'd0, L, L);
    tbl[21] = mkv(L, L, H, H, H, L, L, 4'd3,  2'd1, H, L);

    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].r, tbl[i].startn, tbl[i].stopn, tbl[i].clearn, tbl[i].door,
             tbl[i].timer, tbl[i].tick, tbl[i].pl);
      step();
      check($sformatf("vec%0d_state", i), {6'b0, bus.state}, {6'b0, tbl[i].st});
      check($sformatf("vec%0d_mag", i),   {7'b0, bus.mag_on}, {7'b0, tbl[i].mag});
      check($sformatf("vec%0d_done", i),  {7'b0, bus.done}, {7'b0, tbl[i].done});
    end

    // Door opens mid-COOK: drive must drop before the next edge, then PAUSE.
    set_in(L, H, H, H, L, L, L, 4'd3);
    #1;
    check("door_gate_mag", {7'b0, bus.mag_on}, 8'd0);
    check("door_gate_state", {6'b0, bus.state}, 8'd1);
    step();
    check("door_pause_state", {6'b0, bus.state}, 8'd2);
    set_in(L, L, H, H, H, L, L, 4'd3);
    step();
    check("resume_state", {6'b0, bus.state}, 8'd1);
    check("resume_mag", {7'b0, bus.mag_on}, 8'd1);
    set_in(L, H, H, H, H, L, H, 4'd3);
    step();
    step();
    check("resume_cnt2_mag", {7'b0, bus.mag_on}, 8'd1);
    step();
    check("resume_cnt3_mag", {7'b0, bus.mag_on}, 8'd0);

    // Level 4 of 10 over 20 ticks: on for phases 0-3 of each period.
    set_in(H, H, H, H, H, L, L, 4'd4);
    step();
    set_in(L, L, H, H, H, L, L, 4'd4);
    step();
    check("duty_t0_mag", {7'b0, bus.mag_on}, 8'd1);
    for (int k = 1; k <= 20; k++) begin
      set_in(L, H, H, H, H, L, H, 4'd4);
      step();
      check($sformatf("duty_t%0d_mag", k), {7'b0, bus.mag_on}, {7'b0, ((k % 10) < 4)});
      check($sformatf("duty_t%0d_state", k), {6'b0, bus.state}, 8'd1);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(63, 0) == 0,
             $urandom_range(2, 0) != 0,
             $urandom_range(7, 0) != 0,
             $urandom_range(15, 0) != 0,
             $urandom_range(7, 0) != 0,
             $urandom_range(15, 0) == 0,
             $urandom_range(1, 0) == 1,
             4'($urandom_range(15, 0)));
      step();
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
